// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - state type and slice geometry helpers for serial_subtractor
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int n_slices(input int word_width, input int unit_width);
        return word_width / unit_width + (((word_width % unit_width) != 0) ? 1 : 0);
    endfunction

    // Slice 0 is the short junior slice whenever the word does not divide evenly.
    function automatic int slice_width(input int word_width, input int unit_width, input int i);
        int j;
        j = word_width % unit_width;
        return (j != 0 && i == 0) ? j : unit_width;
    endfunction

    function automatic int slice_offset(input int word_width, input int unit_width, input int i);
        return (i == 0) ? 0 : slice_width(word_width, unit_width, 0) + (i - 1) * unit_width;
    endfunction

endpackage

// File: rtl/serial_subtractor_sub_unit.sv
// rtl/serial_subtractor_sub_unit.sv - combinational UNIT_WIDTH-bit subtractor slice
module serial_subtractor_sub_unit #(
    parameter int UNIT_WIDTH = 4
) (
    input  logic [UNIT_WIDTH-1:0] a,
    input  logic [UNIT_WIDTH-1:0] b,
    input  logic                  borrow_in,
    output logic [UNIT_WIDTH-1:0] d,
    output logic                  borrow_out
);

    assign {borrow_out, d} = {1'b0, a} - {1'b0, b} - {{UNIT_WIDTH{1'b0}}, borrow_in};

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - unit-serial subtractor r = a - b - borrow_in; SERIAL_SUBTRACTOR_FLAGS_EN adds zero/neg/ovf flags
import serial_subtractor_pkg::*;

module serial_subtractor #(
    parameter int UNIT_WIDTH = 4,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  borrow_i,
    input  logic [WORD_WIDTH-1:0] a_i,
    input  logic [WORD_WIDTH-1:0] b_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [WORD_WIDTH-1:0] r_o,
    output logic                  borrow_o
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    ,
    output logic                  zero_o,
    output logic                  neg_o,
    output logic                  ovf_o
`endif
);

    localparam int N  = n_slices(WORD_WIDTH, UNIT_WIDTH);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t state_q, state_d;
    logic [WORD_WIDTH-1:0] a_q, b_q, r_q;
    logic                  borrow_q;
    logic [CW-1:0]         cnt_q;

    logic accept, done_ack, last_slice;
    assign accept     = valid_i & ready_o;
    assign done_ack   = valid_o & ready_i;
    assign last_slice = (cnt_q == LAST);

    int                    width_s, off_s;
    logic [UNIT_WIDTH-1:0] mask_u, a_s, b_s, d_u;
    logic                  bo_u, borrow_next;
    logic [WORD_WIDTH-1:0] mask_w, d_w;

    always_comb begin
        width_s = slice_width(WORD_WIDTH, UNIT_WIDTH, int'(cnt_q));
        off_s   = slice_offset(WORD_WIDTH, UNIT_WIDTH, int'(cnt_q));
        mask_u  = {UNIT_WIDTH{1'b1}} >> (UNIT_WIDTH - width_s);
        a_s     = UNIT_WIDTH'(a_q >> off_s) & mask_u;
        b_s     = UNIT_WIDTH'(b_q >> off_s) & mask_u;
    end

    serial_subtractor_sub_unit #(.UNIT_WIDTH(UNIT_WIDTH)) u_sub (
        .a          (a_s),
        .b          (b_s),
        .borrow_in  (borrow_q),
        .d          (d_u),
        .borrow_out (bo_u)
    );

    // Junior slice: operands are zero-extended, so a negative result sets every bit from width_s up.
    always_comb begin
        borrow_next = (width_s == UNIT_WIDTH) ? bo_u : |(d_u >> width_s);
        mask_w = '0;
        mask_w[UNIT_WIDTH-1:0] = mask_u;
        mask_w = mask_w << off_s;
        d_w = '0;
        d_w[UNIT_WIDTH-1:0] = d_u & mask_u;
        d_w = d_w << off_s;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    if (done_ack)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state_q == IDLE);
        valid_o = (state_q == DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q      <= a_i;
                        b_q      <= b_i;
                        r_q      <= '0;
                        borrow_q <= borrow_i;
                        cnt_q    <= '0;
                    end
                end
                RUN: begin
                    r_q      <= (r_q & ~mask_w) | d_w;
                    borrow_q <= borrow_next;
                    cnt_q    <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign r_o      = r_q;
    assign borrow_o = borrow_q;

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    assign zero_o = valid_o & (r_q == '0);
    assign neg_o  = valid_o & r_q[WORD_WIDTH-1];
    assign ovf_o  = valid_o & (a_q[WORD_WIDTH-1] != b_q[WORD_WIDTH-1])
                            & (r_q[WORD_WIDTH-1] != a_q[WORD_WIDTH-1]);
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed bench for serial_subtractor at W16/U4, W10/U4 and W16/U16
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, ready_i, borrow_i;
    logic [15:0] a, b;

    logic        rdy16, val16, bo16;
    logic [15:0] r16;
    logic        rdy10, val10, bo10;
    logic [9:0]  r10;
    logic        rdyf, valf, bof;
    logic [15:0] rf;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    logic        z16, n16, o16, z10, n10, o10, zf, nf, of;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.UNIT_WIDTH(4), .WORD_WIDTH(16)) u16 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy16), .borrow_i(borrow_i),
        .a_i(a), .b_i(b), .valid_o(val16), .ready_i(ready_i), .r_o(r16), .borrow_o(bo16)
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
        , .zero_o(z16), .neg_o(n16), .ovf_o(o16)
`endif
    );

    serial_subtractor #(.UNIT_WIDTH(4), .WORD_WIDTH(10)) u10 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy10), .borrow_i(borrow_i),
        .a_i(a[9:0]), .b_i(b[9:0]), .valid_o(val10), .ready_i(ready_i), .r_o(r10), .borrow_o(bo10)
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
        , .zero_o(z10), .neg_o(n10), .ovf_o(o10)
`endif
    );

    serial_subtractor #(.UNIT_WIDTH(16), .WORD_WIDTH(16)) ufull (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdyf), .borrow_i(borrow_i),
        .a_i(a), .b_i(b), .valid_o(valf), .ready_i(ready_i), .r_o(rf), .borrow_o(bof)
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
        , .zero_o(zf), .neg_o(nf), .ovf_o(of)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic bin);
        a        = av;
        b        = bv;
        borrow_i = bin;
        valid_i  = 1'b1;
        @(posedge clk); #1;
        valid_i  = 1'b0;
        a        = 16'h0;
        b        = 16'h0;
        borrow_i = 1'b0;
    endtask

    task automatic wait_done();
        int l16, l10, lf;
        l16 = 0; l10 = 0; lf = 0;
        for (int c = 1; c <= 30; c++) begin
            if (val16 && l16 == 0) l16 = c;
            if (val10 && l10 == 0) l10 = c;
            if (valf && lf == 0) lf = c;
            if (val16 && val10 && valf) break;
            @(posedge clk); #1;
        end
        check("lat16", l16, 5);
        check("lat10", l10, 4);
        check("lat_full", lf, 2);
    endtask

    task automatic release_result();
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        check("rel_ready16", rdy16, 1);
        check("rel_ready10", rdy10, 1);
        check("rel_ready_full", rdyf, 1);
        check("rel_valid16", val16, 0);
    endtask

    task automatic run_vec(input string tag,
                           input logic [15:0] av, input logic [15:0] bv, input logic bin,
                           input logic [15:0] e16, input logic eb16,
                           input logic [9:0] e10, input logic eb10,
                           input logic [2:0] eflags);
        start_op(av, bv, bin);
        wait_done();
        check({tag, "_r16"}, r16, e16);
        check({tag, "_bo16"}, bo16, eb16);
        check({tag, "_r10"}, r10, e10);
        check({tag, "_bo10"}, bo10, eb10);
        check({tag, "_rfull"}, rf, e16);
        check({tag, "_bofull"}, bof, eb16);
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
        check({tag, "_flags16"}, {z16, n16, o16}, eflags);
        check({tag, "_flagsfull"}, {zf, nf, of}, eflags);
`else
        if (eflags === 3'bxxx) check({tag, "_flags_unused"}, 0, 1);
`endif
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; borrow_i = 1'b0; a = '0; b = '0;
        #1;
        check("rst_valid16", val16, 0);
        check("rst_r16", r16, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_ready16", rdy16, 1);
        check("post_rst_ready10", rdy10, 1);
        check("post_rst_bo16", bo16, 0);

        // flags packed as {zero, neg, ovf}
        run_vec("v1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 10'h000, 1'b0, 3'b000);
        release_result();
        run_vec("v2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 10'h3FF, 1'b1, 3'b010);

        // backpressure: result held, operand pulse ignored
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a = 16'h0777; b = 16'h0111; valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            @(posedge clk); #1;
            check("bp_valid16", val16, 1);
            check("bp_ready16", rdy16, 0);
            check("bp_r16", r16, 16'hFFFF);
        end
        valid_i = 1'b0;
        release_result();
        @(posedge clk); #1;
        check("bp_still_idle16", rdy16, 1);

        run_vec("v3", 16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 10'h3FF, 1'b1, 3'b001);
        release_result();
        run_vec("v4", 16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 10'h000, 1'b0, 3'b100);
        release_result();
        run_vec("v5", 16'h03FF, 16'h0001, 1'b0, 16'h03FE, 1'b0, 10'h3FE, 1'b0, 3'b000);
        release_result();
        run_vec("v6", 16'hABCD, 16'hABCD, 1'b1, 16'hFFFF, 1'b1, 10'h3FF, 1'b1, 3'b010);
        release_result();
        run_vec("v7", 16'h0100, 16'h0003, 1'b0, 16'h00FD, 1'b0, 10'h0FD, 1'b0, 3'b000);
        release_result();

        // reset after the second RUN cycle aborts the operation
        start_op(16'hFFFF, 16'h1111, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_valid16", val16, 0);
        check("abort_r16", r16, 0);
        check("abort_bo16", bo16, 0);
        check("abort_valid_full", valf, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_ready16", rdy16, 1);
        check("abort_ready_full", rdyf, 1);
        run_vec("v8", 16'h03FF, 16'h0001, 1'b0, 16'h03FE, 1'b0, 10'h3FE, 1'b0, 3'b000);
        release_result();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
